// File: rtl/pixel_mux_stream.sv
// pixel_mux_stream
//   N_IN-channel colour-word selector with valid/ready streaming. The chosen word
//   goes through a registered output stage backed by one skid register, so the
//   upstream ready never depends combinationally on out_ready. The channel is
//   picked directly from sel, or round-robin starting at rr_ptr. Each output word
//   carries the index of the channel it came from.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = direct (sel), 1 = round-robin
//   sel        in   [SEL_W-1:0]       channel select in direct mode
//   in_data    in   [N_IN*DATA_W-1:0] channel k at [k*DATA_W +: DATA_W]
//   in_valid   in   [N_IN-1:0]        per-channel valid
//   in_ready   out  [N_IN-1:0]        per-channel ready, one-hot or zero
//   out_data   out  [DATA_W-1:0]      selected colour word
//   out_ch     out  [SEL_W-1:0]       source channel of out_data
//   out_valid  out  out_data/out_ch valid
//   out_ready  in   downstream ready
//   sel_err    out  one-cycle pulse: direct mode with sel >= N_IN
module pixel_mux_stream #(
    parameter int DATA_W = 24,
    parameter int N_IN   = 8,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN-1:0]          in_valid,
    output logic [N_IN-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    // One extra bit so comparisons against N_IN work even when N_IN == 2**SEL_W.
    localparam logic [SEL_W:0]   N_IN_W  = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q,   out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] sr_data_q,  sr_data_d;
    logic [SEL_W-1:0]  sr_ch_q,    sr_ch_d;
    logic              skid_full_q, skid_full_d;
    logic [SEL_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic              sel_err_q,  sel_err_d;

    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic [SEL_W:0]    cand;
    logic [DATA_W-1:0] in_word;
    logic              accept;
    logic              drain;

    // Grant selection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        if (!mode) begin
            if ({1'b0, sel} < N_IN_W) begin
                grant       = sel;
                grant_valid = 1'b1;
            end
        end else begin
            // Scan from the farthest offset back to rr_ptr so the nearest valid channel wins.
            for (int i = N_IN - 1; i >= 0; i--) begin
                cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
                if (cand >= N_IN_W) begin
                    cand = cand - N_IN_W;
                end
                if (in_valid[cand[SEL_W-1:0]]) begin
                    grant       = cand[SEL_W-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign in_word = in_data[int'(grant)*DATA_W +: DATA_W];
    assign accept  = grant_valid & in_valid[grant] & ~skid_full_q;
    assign drain   = out_valid_q & out_ready;

    // Ready only depends on skid occupancy, never on out_ready.
    always_comb begin
        in_ready = '0;
        if (rst_n && grant_valid && !skid_full_q) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output register / skid register next state, strict FIFO order.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sr_data_d   = sr_data_q;
        sr_ch_d     = sr_ch_q;
        skid_full_d = skid_full_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = ~mode & ({1'b0, sel} >= N_IN_W);

        if (skid_full_q) begin
            // in_ready is low while the skid is full, so only a drain can happen.
            if (drain) begin
                out_data_d  = sr_data_q;
                out_ch_d    = sr_ch_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = in_word;
                out_ch_d    = grant;
                out_valid_d = 1'b1;
            end else begin
                sr_data_d   = in_word;
                sr_ch_d     = grant;
                skid_full_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            rr_ptr_d = (grant == LAST_CH) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid payload is reset as well so a mid-stream reset leaves no stale word behind.
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sr_data_q   <= '0;
            sr_ch_q     <= '0;
            skid_full_q <= 1'b0;
            rr_ptr_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sr_data_q   <= sr_data_d;
            sr_ch_q     <= sr_ch_d;
            skid_full_q <= skid_full_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pixel_mux_stream.sv
// Directed bench for pixel_mux_stream: one 8-channel instance and one 5-channel
// instance (round-robin wrap at N_IN, sel_err for out-of-range sel).
module tb_pixel_mux_stream;

    logic clk;
    logic rst_n;

    // 8-channel instance
    logic          a_mode;
    logic [2:0]    a_sel;
    logic [191:0]  a_in_data;
    logic [7:0]    a_in_valid;
    logic [7:0]    a_in_ready;
    logic [23:0]   a_out_data;
    logic [2:0]    a_out_ch;
    logic          a_out_valid;
    logic          a_out_ready;
    logic          a_sel_err;

    // 5-channel instance
    logic          b_mode;
    logic [2:0]    b_sel;
    logic [119:0]  b_in_data;
    logic [4:0]    b_in_valid;
    logic [4:0]    b_in_ready;
    logic [23:0]   b_out_data;
    logic [2:0]    b_out_ch;
    logic          b_out_valid;
    logic          b_out_ready;
    logic          b_sel_err;

    int total = 0;
    int bad   = 0;

    pixel_mux_stream #(.DATA_W(24), .N_IN(8), .SEL_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err)
    );

    pixel_mux_stream #(.DATA_W(24), .N_IN(5), .SEL_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances; returns on a falling edge with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [23:0] got_q[$];
    int          sent;
    int          exp_ch[4] = '{2, 5, 2, 5};

    initial begin
        rst_n       = 1'b0;
        a_mode      = 1'b0;
        a_sel       = 3'd0;
        a_in_valid  = 8'hFF;
        a_out_ready = 1'b1;
        b_mode      = 1'b0;
        b_sel       = 3'd0;
        b_in_valid  = 5'h00;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) a_in_data[k*24 +: 24] = 24'h000100 + 24'(k);
        for (int k = 0; k < 5; k++) b_in_data[k*24 +: 24] = 24'h000200 + 24'(k);

        // 1: reset held with all channels valid
        #3;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_hold_out_data", 32'(a_out_data), 32'd0);
        check("rst_hold_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_sel_err", 32'(a_sel_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(a_in_ready), 32'h01);
        tick();
        check("rel_out_valid", 32'(a_out_valid), 32'd1);
        check("rel_out_data", 32'(a_out_data), 32'h000100);
        check("rel_out_ch", 32'(a_out_ch), 32'd0);

        // 2: direct select of channel 3
        a_sel = 3'd3;
        a_in_valid = 8'b0000_1000;
        a_in_data[3*24 +: 24] = 24'hFF0000;
        #1;
        check("dir_in_ready", 32'(a_in_ready), 32'h08);
        tick();
        check("dir_out_data", 32'(a_out_data), 32'hFF0000);
        check("dir_out_ch", 32'(a_out_ch), 32'd3);
        check("dir_out_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 8'h00;
        tick();
        check("dir_idle_valid", 32'(a_out_valid), 32'd0);

        // 3: backpressure on channel 0 streaming 1,2,3,4
        do_reset();
        a_mode = 1'b0;
        a_sel  = 3'd0;
        sent   = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_in_valid  = (sent < 4) ? 8'h01 : 8'h00;
            a_in_data[23:0] = 24'(sent + 1);
            a_out_ready = !(cyc >= 1 && cyc <= 3);
            #1;
            if (cyc == 1) check("bp_ready_c1", 32'(a_in_ready), 32'h01);
            if (cyc == 2) check("bp_ready_c2", 32'(a_in_ready), 32'h00);
            if (cyc == 2 || cyc == 3) check("bp_hold_data", 32'(a_out_data), 32'd1);
            if (a_out_valid && a_out_ready) got_q.push_back(a_out_data);
            if (a_in_valid[0] && a_in_ready[0]) sent++;
            tick();
        end
        check("bp_sent", 32'(sent), 32'd4);
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("bp_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i + 1));

        // 4: round-robin over 8 channels, then only ch2 and ch5
        do_reset();
        a_mode      = 1'b1;
        a_in_valid  = 8'hFF;
        a_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) a_in_data[k*24 +: 24] = 24'h00A000 + 24'(k);
        for (int i = 0; i < 9; i++) begin
            #1;
            check("rr8_in_ready", 32'(a_in_ready), 32'(1 << (i % 8)));
            tick();
            check("rr8_out_ch", 32'(a_out_ch), 32'(i % 8));
            check("rr8_out_data", 32'(a_out_data), 32'h00A000 + 32'(i % 8));
        end
        a_in_valid = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr25_in_ready", 32'(a_in_ready), 32'(1 << exp_ch[i]));
            tick();
            check("rr25_out_ch", 32'(a_out_ch), 32'(exp_ch[i]));
        end

        // 5: wrap at N_IN=5, then out-of-range direct select
        a_in_valid = 8'h00;
        do_reset();
        b_mode     = 1'b1;
        b_in_valid = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr5_out_ch", 32'(b_out_ch), 32'(i % 5));
        end
        b_mode = 1'b0;
        b_sel  = 3'd6;
        #1;
        check("selerr_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        check("selerr_pulse", 32'(b_sel_err), 32'd1);
        check("selerr_no_accept", 32'(b_out_valid), 32'd0);
        b_sel = 3'd1;
        tick();
        check("selerr_clear", 32'(b_sel_err), 32'd0);
        check("sel1_out_valid", 32'(b_out_valid), 32'd1);
        check("sel1_out_ch", 32'(b_out_ch), 32'd1);
        b_in_valid = 5'h00;

        // 6: reset with output and skid registers both full
        do_reset();
        a_mode      = 1'b0;
        a_sel       = 3'd0;
        a_in_valid  = 8'h01;
        a_out_ready = 1'b0;
        a_in_data[23:0] = 24'h000111;
        tick();
        a_in_data[23:0] = 24'h000222;
        tick();
        #1;
        check("full_in_ready", 32'(a_in_ready), 32'd0);
        check("full_out_data", 32'(a_out_data), 32'h000111);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_out_data", 32'(a_out_data), 32'd0);
        check("midrst_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_in_data[23:0] = 24'hABCDEF;
        a_out_ready = 1'b1;
        tick();
        check("post_rst_data", 32'(a_out_data), 32'hABCDEF);
        check("post_rst_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 8'h00;
        tick();
        check("post_rst_empty", 32'(a_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
